wb_master_ctrl: RTL and testbench
=================================

// Module: wb_master_ctrl
// PURPOSE
//   Wishbone B4 pipelined single-transfer initiator. Accepts one read/write command
//   on a valid/ready port and drives cyc/stb/we/adr/dat to a responder such as
//   the UART peripheral. Honours stall, waits for ack and returns read data or a
//   timeout error on a valid/ready response port. Sits between a host/debug
//   front-end and the peripheral bus.
// PARAMETERS
//   ADDR_WIDTH      8    width of wb_adr_o / cmd_adr
//   TIMEOUT_CYCLES  255  cycles with cyc high and no ack before abort; >=2
// PORTS
//   wb_clk_i    in   1           single clock, all logic on rising edge
//   wb_rst_i    in   1           reset, asynchronous, active-high
//   cmd_valid   in   1           command present
//   cmd_ready   out  1           command accepted when valid&ready
//   cmd_we      in   1           1=write, 0=read
//   cmd_adr     in   ADDR_WIDTH  target address
//   cmd_dat     in   32          write data
//   rsp_valid   out  1           response present
//   rsp_ready   in   1           response consumed when valid&ready
//   rsp_dat     out  32          read data; 0 for writes and errors
//   rsp_err     out  1           1=timeout abort
//   wb_cyc_o    out  1           bus cycle
//   wb_stb_o    out  1           strobe
//   wb_we_o     out  1           write enable
//   wb_adr_o    out  ADDR_WIDTH  address
//   wb_dat_o    out  32          write data
//   wb_dat_i    in   32          read data, sampled with ack
//   wb_ack_i    in   1           acknowledge
//   wb_stall_i  in   1           responder stall
// BEHAVIOUR
//   Reset: state IDLE; every output 0 except cmd_ready=1; timer 0.
//   All outputs registered except cmd_ready = (state==IDLE).
//   States and transitions:
//     IDLE: cmd_valid -> latch we/adr/dat onto wb_*_o, cyc=stb=1, timer=0 -> REQ.
//     REQ:  stb held with constant adr/we/dat while wb_stall_i=1.
//           !stall & ack (same-cycle ack) -> cyc=stb=0, capture -> RESP.
//           !stall & !ack -> stb=0, cyc=1 -> WAIT.
//     WAIT: ack -> cyc=0, capture -> RESP.
//     RESP: rsp_valid=1, outputs stable until rsp_ready; then rsp_valid=0 -> IDLE.
//   Capture: rsp_dat = we ? 0 : wb_dat_i; rsp_err=0.
//   Timeout: timer increments every cycle in REQ/WAIT. Reaching TIMEOUT_CYCLES
//     with no ack -> cyc=stb=0, rsp_dat=0, rsp_err=1 -> RESP.
//     Ack in the expiry cycle wins: normal capture, err=0.
//   Latency: zero-stall responder with combinational ack: cmd accepted cycle 0,
//     stb high cycle 1, rsp_valid cycle 2.
//   No back-to-back: the next command is accepted only the cycle after the
//     response handshake. No pipelined outstanding requests.
//   wb_ack_i outside REQ/WAIT is ignored: no state change, no response.
//   Async reset mid-cycle drops cyc/stb immediately and discards the pending
//     response.
//   Timer width = $clog2(TIMEOUT_CYCLES+1); saturates and never wraps.
// STRUCTURE
//   Shared include wb_defs.vh: state encodings (IDLE/REQ/WAIT/RESP, 2-bit) and
//     WB_DATA_WIDTH=32.
//   One sub-module is natural: wb_timeout_ctr (clear, enable, expired flag).
//     The FSM and bus registers stay in wb_master_ctrl.
// TESTING
//   1 Write 0xA5 to adr 0x00, stall=0, ack=cyc&stb -> one stb cycle with
//     we=1, dat_o=0xA5; rsp_valid 2 cycles after accept; err=0, dat=0.
//   2 Read adr 0x04, stall=1 for 3 cycles, ack 2 cycles after stall drops with
//     dat_i=0x12345678 -> stb high 4 cycles, adr stable;
//     rsp_dat=0x12345678, err=0.
//   3 TIMEOUT_CYCLES=16, no ack ever -> cyc drops after 16 cycles in REQ/WAIT;
//     rsp_err=1, rsp_dat=0; next command accepted normally.
//   4 rsp_ready held low 10 cycles after completion -> rsp_* stable, cmd_ready=0,
//     cmd_valid ignored; accepts 1 cycle after handshake.
//   5 Spurious wb_ack_i pulse in IDLE and in RESP -> no rsp_valid change,
//     no state change.
//   6 Assert wb_rst_i while in WAIT -> cyc/stb/rsp_valid 0 with no clock edge;
//     cmd_ready=1 after release.

Source files
------------

// File: rtl/wb_master_ctrl_pkg.sv
// Shared definitions for the Wishbone single-transfer initiator: data width and
// the controller state encoding.
package wb_master_ctrl_pkg;

  localparam int WB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog. It counts the cycles spent with a request outstanding and
// flags the cycle in which the TIMEOUT_CYCLES-th such cycle is completing.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   C_MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != C_MAX)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // r_count holds completed cycles, so the last allowed cycle sees TIMEOUT-1.
  assign o_expired = i_enable && (r_count >= C_LAST);

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone B4 pipelined initiator issuing one read or write per command and
// returning read data, or a timeout error, on a valid/ready response port.
module wb_master_ctrl
  import wb_master_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDR_WIDTH-1:0]    cmd_adr,
  input  logic [WB_DATA_WIDTH-1:0] cmd_dat,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WB_DATA_WIDTH-1:0] rsp_dat,
  output logic                     rsp_err,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [ADDR_WIDTH-1:0]    wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i
);

  state_t                   r_state, w_state;
  logic                     r_cyc, w_cyc;
  logic                     r_stb, w_stb;
  logic                     r_we, w_we;
  logic [ADDR_WIDTH-1:0]    r_adr, w_adr;
  logic [WB_DATA_WIDTH-1:0] r_dat, w_dat;
  logic                     r_rsp_valid, w_rsp_valid;
  logic [WB_DATA_WIDTH-1:0] r_rsp_dat, w_rsp_dat;
  logic                     r_rsp_err, w_rsp_err;

  logic w_timer_en;
  logic w_timer_clear;
  logic w_expired;
  logic w_ack_hit;

  assign cmd_ready     = (r_state == ST_IDLE);
  assign w_timer_en    = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_timer_clear = cmd_ready && cmd_valid;
  // An ack only counts once the strobe has been taken (not stalled) or while waiting.
  assign w_ack_hit     = wb_ack_i &&
                         ((r_state == ST_WAIT) || ((r_state == ST_REQ) && !wb_stall_i));

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state     = r_state;
    w_cyc       = r_cyc;
    w_stb       = r_stb;
    w_we        = r_we;
    w_adr       = r_adr;
    w_dat       = r_dat;
    w_rsp_valid = r_rsp_valid;
    w_rsp_dat   = r_rsp_dat;
    w_rsp_err   = r_rsp_err;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_we    = cmd_we;
          w_adr   = cmd_adr;
          w_dat   = cmd_dat;
          w_cyc   = 1'b1;
          w_stb   = 1'b1;
          w_state = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (w_ack_hit) begin
          w_cyc       = 1'b0;
          w_stb       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_dat   = r_we ? '0 : wb_dat_i;
          w_rsp_err   = 1'b0;
          w_state     = ST_RESP;
        end else if (w_expired) begin
          w_cyc       = 1'b0;
          w_stb       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_dat   = '0;
          w_rsp_err   = 1'b1;
          w_state     = ST_RESP;
        end else if ((r_state == ST_REQ) && !wb_stall_i) begin
          w_stb   = 1'b0;
          w_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cyc       <= w_cyc;
      r_stb       <= w_stb;
      r_we        <= w_we;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_dat   <= w_rsp_dat;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Scoreboard bench for wb_master_ctrl: a behavioural responder, a transaction-level
// reference model and a monitor that checks bus activity and responses.
module tb_wb_master_ctrl;

  localparam int AW = 8;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [31:0]   cmd_dat = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_dat;
  logic          rsp_err;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [31:0]   wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_stall_i = 1'b0;

  always #5 clk = ~clk;

  wb_master_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i)
  );

  // One transaction: stimulus, responder behaviour and expected outcome.
  typedef struct {
    bit          we;
    logic [7:0]  adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          stall;
    int          dly;
    bit          no_ack;
    int          rdy;
    int          exp_cyc;
    int          exp_stb;
    bit          exp_err;
    logic [31:0] exp_dat;
  } txn_t;

  txn_t exp_q[$];
  txn_t plan_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   busy = 1'b0;
  bit   spur_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Ack arrives stall+1+dly cycles into the bus cycle; the bus gives up after T cycles.
  function automatic txn_t model(input txn_t t);
    int need;
    bit ok;
    need      = t.stall + 1 + t.dly;
    ok        = !t.no_ack && (need <= T);
    t.exp_stb = (t.stall + 1 < T) ? t.stall + 1 : T;
    t.exp_cyc = ok ? need : T;
    t.exp_err = !ok;
    t.exp_dat = (ok && !t.we) ? t.rdat : 32'h0;
    return t;
  endfunction

  task automatic issue(input bit we, input logic [7:0] adr, input logic [31:0] wdat,
                       input logic [31:0] rdat, input int stall, input int dly,
                       input bit no_ack, input int rdy);
    txn_t t;
    int   guard;
    t.we = we; t.adr = adr; t.wdat = wdat; t.rdat = rdat;
    t.stall = stall; t.dly = dly; t.no_ack = no_ack; t.rdy = rdy;
    t = model(t);
    exp_q.push_back(t);
    plan_q.push_back(t);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = wdat;
    guard = 0;
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      bound_expired("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || busy) bound_expired("drain");
  endtask

  // Responder: stalls, then acks after the planned delay, or never.
  initial begin : responder
    txn_t p;
    bit   active;
    int   stall_left, wait_cnt;
    active = 1'b0; stall_left = 0; wait_cnt = 0;
    p.no_ack = 1'b1; p.dly = 0; p.rdat = '0; p.stall = 0;
    forever begin
      @(negedge clk);
      wb_ack_i   = 1'b0;
      wb_stall_i = 1'b0;
      wb_dat_i   = $urandom;
      if (rst || !wb_cyc_o) begin
        active = 1'b0;
        if (spur_ack) begin
          wb_ack_i = 1'b1;
          spur_ack = 1'b0;
        end
      end else begin
        if (!active) begin
          active = 1'b1;
          if (plan_q.size() > 0) p = plan_q.pop_front();
          else p.no_ack = 1'b1;
          stall_left = p.stall;
          wait_cnt   = p.dly;
        end
        if (wb_stb_o) begin
          if (stall_left > 0) begin
            wb_stall_i = 1'b1;
            stall_left--;
          end else if (!p.no_ack && p.dly == 0) begin
            wb_ack_i = 1'b1;
            wb_dat_i = p.rdat;
          end
        end else if (!p.no_ack) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            wb_ack_i = 1'b1;
            wb_dat_i = p.rdat;
          end
        end
      end
    end
  end

  // Response consumer: holds rsp_ready low for the planned number of cycles.
  initial begin : ready_drv
    int hold;
    hold = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid && exp_q.size() > 0) begin
        if (hold < exp_q[0].rdy) begin
          rsp_ready = 1'b0;
          hold++;
        end else begin
          rsp_ready = 1'b1;
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
        hold = 0;
      end
    end
  end

  initial begin : monitor
    int lat, cyc_n, stb_n;
    bit seen, exp_ready;
    lat = 0; cyc_n = 0; stb_n = 0; seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        plan_q.delete();
        busy = 1'b0;
      end else begin
        exp_ready = !busy;
        if (busy) begin
          lat++;
          if (wb_cyc_o) begin
            cyc_n++;
            check("bus_we", 32'(wb_we_o), 32'(exp_q[0].we));
            check("bus_adr", 32'(wb_adr_o), 32'(exp_q[0].adr));
            check("bus_dat", wb_dat_o, exp_q[0].wdat);
          end
          if (wb_stb_o) stb_n++;
          if (rsp_valid) begin
            if (!seen) begin
              seen = 1'b1;
              check("rsp_latency", 32'(lat), 32'(exp_q[0].exp_cyc + 1));
            end
            check("rsp_dat", rsp_dat, exp_q[0].exp_dat);
            check("rsp_err", 32'(rsp_err), 32'(exp_q[0].exp_err));
            if (rsp_ready) begin
              check("cyc_cycles", 32'(cyc_n), 32'(exp_q[0].exp_cyc));
              check("stb_cycles", 32'(stb_n), 32'(exp_q[0].exp_stb));
              void'(exp_q.pop_front());
              busy = 1'b0;
            end
          end
        end else begin
          check("idle_cyc", 32'(wb_cyc_o), 32'h0);
          check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        end
        check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        if (!busy && cmd_valid && cmd_ready) begin
          if (exp_q.size() == 0) begin
            bound_expired("accept_without_command");
          end else begin
            busy = 1'b1;
            lat = 0; cyc_n = 0; stb_n = 0; seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int guard;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_dat", rsp_dat, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_cyc", 32'(wb_cyc_o), 32'h0);
    check("rst_stb", 32'(wb_stb_o), 32'h0);
    check("rst_we", 32'(wb_we_o), 32'h0);
    check("rst_adr", 32'(wb_adr_o), 32'h0);
    check("rst_dat_o", wb_dat_o, 32'h0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;

    // Zero-stall write, stalled read, timeouts and the ack-at-expiry boundary.
    issue(1'b1, 8'h00, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 0);
    issue(1'b0, 8'h04, 32'h0, 32'h1234_5678, 3, 2, 1'b0, 0);
    issue(1'b0, 8'h08, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b1, 0);
    issue(1'b1, 8'h0C, 32'h5555_AAAA, 32'h0, 2, 0, 1'b1, 1);
    issue(1'b0, 8'h10, 32'h0, 32'h0BAD_CAFE, 2, 13, 1'b0, 0);
    issue(1'b0, 8'h14, 32'h0, 32'h7777_8888, 0, 16, 1'b0, 0);
    issue(1'b0, 8'h18, 32'h0, 32'h1357_9BDF, 20, 0, 1'b0, 0);
    issue(1'b0, 8'h1C, 32'h0, 32'h2468_ACE0, 1, 1, 1'b0, 0);

    // Response held for 10 cycles while the next command waits.
    issue(1'b0, 8'h20, 32'h0, 32'hFEED_BEEF, 0, 1, 1'b0, 10);
    issue(1'b1, 8'h24, 32'h0102_0304, 32'h0, 0, 0, 1'b0, 0);
    drain();

    // Spurious acks in RESP and in IDLE.
    issue(1'b0, 8'h28, 32'h0, 32'hA1B2_C3D4, 0, 1, 1'b0, 6);
    guard = 0;
    while (!rsp_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) bound_expired("rsp_valid_for_spurious");
    spur_ack = 1'b1;
    drain();
    spur_ack = 1'b1;
    repeat (5) @(negedge clk);

    // Asynchronous reset while waiting for ack.
    issue(1'b0, 8'h30, 32'h0, 32'hDEAD_BEEF, 0, 8, 1'b0, 0);
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!(wb_cyc_o && !wb_stb_o) && guard < 50);
    if (!(wb_cyc_o && !wb_stb_o)) bound_expired("reach_wait");
    #1 rst = 1'b1;
    #1;
    check("async_rst_cyc", 32'(wb_cyc_o), 32'h0);
    check("async_rst_stb", 32'(wb_stb_o), 32'h0);
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("async_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;

    issue(1'b1, 8'h34, 32'h9999_0000, 32'h0, 0, 0, 1'b0, 0);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom,
            $urandom_range(0, 4), $urandom_range(0, 5),
            ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
